// File: rtl/decoder_4to16_reg.sv
// -----------------------------------------------------------------------------
// decoder_4to16_reg
//
// Registered 4-to-16 one-hot decoder, the receive-side partner of the 16-to-4
// encoder. A 4-bit code arrives over a valid/ready handshake. The matching
// one-hot word appears one cycle later and stays until the consumer takes it.
// The single output register gives full throughput (one code per clock) when
// the consumer is always ready.
//
// Optional feature (compile-time macro DECODER_SWEEP_EN):
//   Defined   - a sweep engine walks codes 0..15 through the output register
//               so downstream one-hot logic can be self-tested.
//   Undefined - no sweep engine. sweep_start is ignored, and sweep_busy and
//               sweep_done are held at 0. The port list is the same.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      synchronous, active-low reset
//   en           in   1      decoder enable, sampled with each accepted code
//   in_valid     in   1      in_code valid
//   in_ready     out  1      block can accept in_code this cycle
//   in_code      in   [0:3]  code, in_code[0] is the MSB
//   out_valid    out  1      out_onehot/out_code valid
//   out_ready    in   1      consumer takes the output beat this cycle
//   out_onehot   out  [0:15] one-hot result; code k sets out_onehot[k]
//   out_code     out  [0:3]  code that produced out_onehot
//   sweep_start  in   1      one-cycle request to start a 16-code sweep
//   sweep_busy   out  1      sweep in progress
//   sweep_done   out  1      one-cycle pulse after code 15 of a sweep is taken
// -----------------------------------------------------------------------------
module decoder_4to16_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:3]  in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:15] out_onehot,
  output logic [0:3]  out_code,
  input  logic        sweep_start,
  output logic        sweep_busy,
  output logic        sweep_done
);

  // Internal vectors are little-endian. Copying an ascending port into a
  // descending vector keeps the numeric value, so in_code[0] (the MSB) lands
  // in code_in[3].
  logic [3:0]  code_in;
  assign code_in = in_code;

  // Code k sets bit k counted from the MSB end. That is the MSB of a
  // descending [15:0] word shifted right by k. Code 0 gives 16'h8000 and
  // code 15 gives 16'h0001.
  function automatic logic [15:0] decode_code(input logic [3:0] code);
    return 16'h8000 >> code;
  endfunction

  // Output register.
  logic        out_valid_q, out_valid_d;
  logic [15:0] onehot_q,    onehot_d;
  logic [3:0]  code_q,      code_d;

  // Reset leaves this flag low until the first edge after rst_n rises. That
  // keeps in_ready low through reset and for that one cycle after it.
  logic        rst_done_q;

  logic        slot;        // output register free or being emptied this cycle
  logic        accept;      // input handshake completes this cycle
  logic        sweep_load;  // sweep engine writes the output register this cycle
  logic [3:0]  sweep_code;  // code the sweep engine is loading

  assign slot = !out_valid_q || out_ready;

`ifdef DECODER_SWEEP_EN
  // ---------------------------------------------------------------------------
  // Sweep engine
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;    // next code to load; wraps 15->0 internally
  logic       last_q,  last_d;   // code 15 is loaded and waiting to be taken
  logic       done_q,  done_d;
  logic       start_taken;

  // NOTE: every signal written in an always_comb gets a default value at the
  // top. Then no path leaves a signal unassigned, and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    done_d      = 1'b0;
    sweep_load  = 1'b0;
    start_taken = sweep_start && (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        // A beat already in the output register stays there. The sweep
        // loads code 0 only at the first free slot.
        if (start_taken) begin
          state_d = S_SWEEP;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
        end
      end

      S_SWEEP: begin
        // sweep_start is ignored in this state.
        if (last_q) begin
          // Code 15 is in the output register. The sweep ends when it is taken.
          if (out_valid_q && out_ready) begin
            state_d = S_IDLE;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (slot) begin
          sweep_load = 1'b1;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            last_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples the values from before the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign sweep_code = cnt_q;
  assign sweep_busy = (state_q == S_SWEEP);
  assign sweep_done = done_q;
  assign in_ready   = slot && rst_done_q && (state_q == S_IDLE) && !start_taken;

`else
  // ---------------------------------------------------------------------------
  // No sweep engine: the handshake depends only on the output register.
  // ---------------------------------------------------------------------------
  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start;

  assign sweep_load = 1'b0;
  assign sweep_code = 4'd0;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
  assign in_ready   = slot && rst_done_q;
`endif

  // ---------------------------------------------------------------------------
  // Output register next state
  // ---------------------------------------------------------------------------
  assign accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    onehot_d    = onehot_q;
    code_d      = code_q;

    if (accept) begin
      // en=0 still produces a valid beat. It carries the code with an
      // all-zero one-hot word.
      out_valid_d = 1'b1;
      code_d      = code_in;
      onehot_d    = en ? decode_code(code_in) : 16'h0000;
    end else if (sweep_load) begin
      // The sweep always decodes, whatever the level of en.
      out_valid_d = 1'b1;
      code_d      = sweep_code;
      onehot_d    = decode_code(sweep_code);
    end else if (out_ready) begin
      // Drain: only the valid flag drops. The data keeps its last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      onehot_q    <= 16'h0000;
      code_q      <= 4'd0;
      rst_done_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      onehot_q    <= onehot_d;
      code_q      <= code_d;
      rst_done_q  <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = onehot_q;
  assign out_code   = code_q;

endmodule

// File: tb/tb_decoder_4to16_reg.sv
// -----------------------------------------------------------------------------
// tb_decoder_4to16_reg
//
// Directed, self-checking bench for decoder_4to16_reg. A table of
// {en, code, expected one-hot} records drives the streaming and enable cases.
// Hand-written sequences cover reset, backpressure and the sweep engine. The
// sweep engine is covered when DECODER_SWEEP_EN is defined; otherwise the
// bench checks that sweep_start has no effect.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_4to16_reg;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [0:3]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] out_onehot;
  logic [0:3]  out_code;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;

  decoder_4to16_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_onehot  (out_onehot),
    .out_code    (out_code),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock. Sampling and driving then happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  code;
    logic [15:0] exp_onehot;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Expected values are entered by hand: code k sets bit k from the MSB end.
    vecs[0]  = '{1'b1, 4'd0,  16'h8000};
    vecs[1]  = '{1'b1, 4'd1,  16'h4000};
    vecs[2]  = '{1'b1, 4'd2,  16'h2000};
    vecs[3]  = '{1'b1, 4'd3,  16'h1000};
    vecs[4]  = '{1'b1, 4'd4,  16'h0800};
    vecs[5]  = '{1'b1, 4'd5,  16'h0400};
    vecs[6]  = '{1'b1, 4'd6,  16'h0200};
    vecs[7]  = '{1'b1, 4'd7,  16'h0100};
    vecs[8]  = '{1'b1, 4'd8,  16'h0080};
    vecs[9]  = '{1'b1, 4'd9,  16'h0040};
    vecs[10] = '{1'b1, 4'd10, 16'h0020};
    vecs[11] = '{1'b1, 4'd11, 16'h0010};
    vecs[12] = '{1'b1, 4'd12, 16'h0008};
    vecs[13] = '{1'b1, 4'd13, 16'h0004};
    vecs[14] = '{1'b1, 4'd14, 16'h0002};
    vecs[15] = '{1'b1, 4'd15, 16'h0001};
    vecs[16] = '{1'b0, 4'd5,  16'h0000};
    vecs[17] = '{1'b1, 4'd10, 16'h0020};
    vecs[18] = '{1'b0, 4'd15, 16'h0000};
    vecs[19] = '{1'b0, 4'd0,  16'h0000};

    // ---------------- Reset with in_valid high ----------------
    rst_n       = 1'b0;
    en          = 1'b1;
    in_valid    = 1'b1;
    in_code     = 4'd3;
    out_ready   = 1'b0;
    sweep_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out_valid",  32'(out_valid),  32'd0);
      check("rst_out_onehot", 32'(out_onehot), 32'h0000);
      check("rst_out_code",   32'(out_code),   32'd0);
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_sweep_busy", 32'(sweep_busy), 32'd0);
      check("rst_sweep_done", 32'(sweep_done), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("post_rst_no_accept", 32'(out_valid), 32'd0);
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b0;

    // ---------------- Streaming table (full throughput) ----------------
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      en       = vecs[i].en;
      in_code  = vecs[i].code;
      #1;
      check($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("stream_valid_%0d", i),  32'(out_valid),  32'd1);
      check($sformatf("stream_code_%0d", i),   32'(out_code),   32'(vecs[i].code));
      check($sformatf("stream_onehot_%0d", i), 32'(out_onehot), 32'(vecs[i].exp_onehot));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid",  32'(out_valid),  32'd0);
    check("drain_onehot", 32'(out_onehot), 32'h0000);

    // ---------------- Backpressure ----------------
    out_ready = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b1;
    in_code   = 4'd3;
    tick();
    in_code = 4'd7;  // offered but must not be accepted while the output is held
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hold_onehot_%0d", i), 32'(out_onehot), 32'h1000);
      check($sformatf("bp_hold_code_%0d", i),   32'(out_code),   32'd3);
      check($sformatf("bp_hold_valid_%0d", i),  32'(out_valid),  32'd1);
      check($sformatf("bp_in_ready_%0d", i),    32'(in_ready),   32'd0);
      tick();
    end
    out_ready = 1'b1;
    in_code   = 4'd9;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_code",   32'(out_code),   32'd9);
    check("bp_next_onehot", 32'(out_onehot), 32'h0040);
    in_valid = 1'b0;
    tick();
    check("bp_drain_valid",  32'(out_valid),  32'd0);
    check("bp_drain_onehot", 32'(out_onehot), 32'h0040);

`ifdef DECODER_SWEEP_EN
    // ---------------- Sweep with random backpressure ----------------
    begin
      int idx;
      int cyc;
      int done_cnt;
      en          = 1'b0;  // the sweep must decode regardless of en
      in_valid    = 1'b1;
      in_code     = 4'd2;  // would corrupt the beat order if ever accepted
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      #1;
      check("sweep_start_in_ready", 32'(in_ready), 32'd0);
      tick();
      sweep_start = 1'b0;
      check("sweep_busy_set", 32'(sweep_busy), 32'd1);
      idx      = 0;
      cyc      = 0;
      done_cnt = 0;
      while (idx < 16 && cyc < 400) begin
        if (sweep_done) done_cnt++;
        sweep_start = ($urandom_range(0, 3) == 0);  // ignored while busy
        out_ready   = 1'($urandom_range(0, 1));
        #1;
        if (sweep_busy && in_ready) begin
          check("sweep_in_ready_busy", 32'(in_ready), 32'd0);
        end
        if (out_valid && out_ready) begin
          check($sformatf("sweep_code_%0d", idx),   32'(out_code),   32'(vecs[idx].code));
          check($sformatf("sweep_onehot_%0d", idx), 32'(out_onehot), 32'(vecs[idx].exp_onehot));
          idx++;
        end
        tick();
        cyc++;
      end
      sweep_start = 1'b0;
      check("sweep_beats",        32'(idx),        32'd16);
      check("sweep_early_done",   32'(done_cnt),   32'd0);
      check("sweep_done_pulse",   32'(sweep_done), 32'd1);
      check("sweep_busy_cleared", 32'(sweep_busy), 32'd0);
      check("sweep_out_empty",    32'(out_valid),  32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      check("sweep_done_one_cycle", 32'(sweep_done), 32'd0);
    end

    // ---------------- Reset during a sweep ----------------
    begin
      int cyc;
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      cyc = 0;
      while (!(out_valid && out_code == 4'd7) && cyc < 50) begin
        tick();
        cyc++;
      end
      check("midsweep_reached_7", 32'(out_code), 32'd7);
      rst_n = 1'b0;
      tick();
      check("midsweep_rst_busy",  32'(sweep_busy), 32'd0);
      check("midsweep_rst_valid", 32'(out_valid),  32'd0);
      check("midsweep_rst_done",  32'(sweep_done), 32'd0);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("midsweep_no_done_%0d", i), 32'(sweep_done), 32'd0);
        check($sformatf("midsweep_no_busy_%0d", i), 32'(sweep_busy), 32'd0);
        check($sformatf("midsweep_no_beat_%0d", i), 32'(out_valid),  32'd0);
        tick();
      end
      en       = 1'b1;
      in_valid = 1'b1;
      in_code  = 4'd12;
      tick();
      in_valid = 1'b0;
      check("resume_valid",  32'(out_valid),  32'd1);
      check("resume_code",   32'(out_code),   32'd12);
      check("resume_onehot", 32'(out_onehot), 32'h0008);
      tick();
    end
`else
    // ---------------- sweep_start has no effect ----------------
    en          = 1'b1;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_code     = 4'd6;
    sweep_start = 1'b1;
    #1;
    check("nosweep_in_ready", 32'(in_ready), 32'd1);
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check("nosweep_code",   32'(out_code),   32'd6);
    check("nosweep_onehot", 32'(out_onehot), 32'h0200);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("nosweep_busy_%0d", i),  32'(sweep_busy), 32'd0);
      check($sformatf("nosweep_done_%0d", i),  32'(sweep_done), 32'd0);
      check($sformatf("nosweep_valid_%0d", i), 32'(out_valid),  32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
